// File: rtl/mem_beh_nrw.sv
// Behavioural NUMPRT-port memory: per-bit write masks, injectable error flags, refresh blocking, protocol-error flags.
// Latency: reads LATENCY cycles (0 = combinational), coll/err one cycle; no backpressure, illegal accesses dropped.
module mem_beh_nrw #(
  parameter int NUMPRT  = 2,
  parameter int AW      = 10,
  parameter int DW      = 32,
  parameter int WORDS   = 1024,
  parameter int LATENCY = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUMPRT-1:0]    read,
  input  logic [NUMPRT-1:0]    write,
  input  logic [NUMPRT*AW-1:0] addr,
  input  logic [NUMPRT*DW-1:0] din,
  input  logic [NUMPRT*DW-1:0] bw,
  input  logic                 refr,
  input  logic [AW-1:0]        inj_addr,
  input  logic                 inj_serr,
  input  logic                 inj_derr,
  output logic [NUMPRT*DW-1:0] dout,
  output logic [NUMPRT-1:0]    dvld,
  output logic [NUMPRT-1:0]    read_serr,
  output logic [NUMPRT-1:0]    read_derr,
  output logic                 coll,
  output logic [NUMPRT-1:0]    err
);

  typedef struct packed {
    logic          vld;
    logic          serr;
    logic          derr;
    logic [DW-1:0] dat;
  } rd_t;

  if (LATENCY < 0 || LATENCY > 15) begin : g_lat_chk
    $fatal(1, "mem_beh_nrw: LATENCY %0d outside 0..15", LATENCY);
  end
  if (NUMPRT < 1 || NUMPRT > 8) begin : g_prt_chk
    $fatal(1, "mem_beh_nrw: NUMPRT %0d outside 1..8", NUMPRT);
  end
  if (64'(WORDS) > (64'(1) << AW)) begin : g_words_chk
    $fatal(1, "mem_beh_nrw: WORDS %0d exceeds 2**AW", WORDS);
  end

  localparam logic [AW:0] WORDS_L = (AW+1)'(WORDS);

  logic [DW-1:0]     mem [WORDS];
  logic [WORDS-1:0]  serr_flg;
  logic [WORDS-1:0]  derr_flg;

  logic [AW-1:0]     a      [NUMPRT];
  logic [DW-1:0]     wr_dat [NUMPRT];
  rd_t               s0     [NUMPRT];
  logic [NUMPRT-1:0] acc;
  logic [NUMPRT-1:0] ok;
  logic [NUMPRT-1:0] rd_ok;
  logic [NUMPRT-1:0] wr_ok;
  logic              inj_ok;
  logic              coll_nxt;

  always_comb begin
    for (int p = 0; p < NUMPRT; p++) begin
      a[p]     = addr[p*AW +: AW];
      acc[p]   = read[p] | write[p];
      ok[p]    = rst && !refr && !(read[p] && write[p]) && ({1'b0, a[p]} < WORDS_L);
      rd_ok[p] = read[p] & ok[p];
      wr_ok[p] = write[p] & ok[p];
    end
    inj_ok = {1'b0, inj_addr} < WORDS_L;
  end

  // Every port computes the fully merged word for its address, applying writers in
  // ascending port order so the highest-index writer of each bit wins; all colliding
  // ports then store the same value.
  always_comb begin
    coll_nxt = 1'b0;
    for (int p = 0; p < NUMPRT; p++) begin
      wr_dat[p] = mem[a[p]];
      for (int q = 0; q < NUMPRT; q++) begin
        if (wr_ok[q] && a[q] == a[p]) begin
          wr_dat[p] = (wr_dat[p] & ~bw[q*DW +: DW]) | (din[q*DW +: DW] & bw[q*DW +: DW]);
          if (q > p && wr_ok[p]) coll_nxt = 1'b1;
        end
      end
    end
  end

  // Reads see pre-edge contents, giving old-data read-during-write on every port pair.
  always_comb begin
    for (int p = 0; p < NUMPRT; p++) begin
      s0[p] = '0;
      if (rd_ok[p]) begin
        s0[p].vld  = 1'b1;
        s0[p].derr = derr_flg[a[p]];
        s0[p].serr = serr_flg[a[p]] & ~derr_flg[a[p]];
        s0[p].dat  = mem[a[p]] ^ DW'(derr_flg[a[p]]);
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int p = 0; p < NUMPRT; p++) begin
      if (wr_ok[p]) mem[a[p]] <= wr_dat[p];
    end
  end

  // Injection is applied after the write clears, so it wins on the same word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      serr_flg <= '0;
      derr_flg <= '0;
    end else begin
      for (int p = 0; p < NUMPRT; p++) begin
        if (wr_ok[p]) begin
          serr_flg[a[p]] <= 1'b0;
          derr_flg[a[p]] <= 1'b0;
        end
      end
      if (inj_ok && inj_serr) serr_flg[inj_addr] <= 1'b1;
      if (inj_ok && inj_derr) derr_flg[inj_addr] <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      coll <= 1'b0;
      err  <= '0;
    end else begin
      coll <= coll_nxt;
      err  <= acc & ~ok;
    end
  end

  if (LATENCY == 0) begin : g_comb
    always_comb begin
      dout      = '0;
      dvld      = '0;
      read_serr = '0;
      read_derr = '0;
      for (int p = 0; p < NUMPRT; p++) begin
        dout[p*DW +: DW] = s0[p].dat;
        dvld[p]          = s0[p].vld;
        read_serr[p]     = s0[p].serr;
        read_derr[p]     = s0[p].derr;
      end
    end
  end else begin : g_pipe
    rd_t pipe [LATENCY][NUMPRT];

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        for (int i = 0; i < LATENCY; i++) begin
          for (int p = 0; p < NUMPRT; p++) pipe[i][p] <= '0;
        end
      end else begin
        for (int p = 0; p < NUMPRT; p++) begin
          pipe[0][p] <= s0[p];
          for (int i = 1; i < LATENCY; i++) pipe[i][p] <= pipe[i-1][p];
        end
      end
    end

    always_comb begin
      dout      = '0;
      dvld      = '0;
      read_serr = '0;
      read_derr = '0;
      for (int p = 0; p < NUMPRT; p++) begin
        dout[p*DW +: DW] = pipe[LATENCY-1][p].dat;
        dvld[p]          = pipe[LATENCY-1][p].vld;
        read_serr[p]     = pipe[LATENCY-1][p].serr;
        read_derr[p]     = pipe[LATENCY-1][p].derr;
      end
    end
  end

endmodule
